// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: command-driven burst controller around a 4-bit PRBS LFSR
// (x^4+x^3+1, period 15). A {seed, length} command seeds the LFSR; the block
// then emits exactly `length` bits over a valid/ready stream and pulses done.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   cmd_valid/ready command handshake; cmd_seed (4'h0 illegal), cmd_len
//   cmd_abort       terminates an active burst
//   bit_out/valid   PRBS bit stream (bit_out = lfsr[0]); bit_ready back-pressure
//   busy            burst in progress (RUN or DONE)
//   done, aborted   one-cycle end-of-burst pulses
//   err_seed        one-cycle pulse when a zero-seed command is rejected
//   bits_sent       bits transferred in the current/last burst
module prbs_burst_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_seed,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_seed,
  output logic [LEN_W-1:0] bits_sent
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       lfsr;
  logic [LEN_W-1:0] remain;
  logic             aborted_q;
  logic             err_seed_q;
  logic [LEN_W-1:0] bits_sent_q;
  logic             handshake;

  assign handshake = (state == ST_RUN) && bit_ready;

  // Controller: state, LFSR, counters and pulse flags in one clocked process
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      lfsr        <= 4'hF;
      remain      <= '0;
      aborted_q   <= 1'b0;
      err_seed_q  <= 1'b0;
      bits_sent_q <= '0;
    end else begin
      aborted_q  <= 1'b0;
      err_seed_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_seed == 4'h0) begin
              // Illegal seed: reject without disturbing LFSR or last count
              err_seed_q <= 1'b1;
            end else begin
              bits_sent_q <= '0;
              if (cmd_len == '0) begin
                state <= ST_DONE;
              end else begin
                lfsr   <= cmd_seed;
                remain <= cmd_len;
                state  <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          if (handshake) begin
            lfsr        <= {lfsr[0] ^ lfsr[1], lfsr[3], lfsr[2], lfsr[1]};
            remain      <= remain - LEN_W'(1);
            bits_sent_q <= bits_sent_q + LEN_W'(1);
            // A coincident abort on the final bit is a normal completion
            if (remain == LEN_W'(1)) begin
              state <= ST_DONE;
            end else if (cmd_abort) begin
              state     <= ST_DONE;
              aborted_q <= 1'b1;
            end
          end else if (cmd_abort) begin
            state     <= ST_DONE;
            aborted_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from flops only
  assign cmd_ready = (state == ST_IDLE);
  assign bit_valid = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign bit_out   = lfsr[0];
  assign aborted   = aborted_q;
  assign err_seed  = err_seed_q;
  assign bits_sent = bits_sent_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Self-checking bench for prbs_burst_ctrl: directed scenarios plus random
// bursts scored against a bit-sequence reference (b[n+4] = b[n] ^ b[n+1]).
module tb_prbs_burst_ctrl;

  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_seed;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_abort;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err_seed;
  logic [LEN_W-1:0] bits_sent;

  int n_checks = 0;
  int n_errors = 0;
  int last_sent = 0;

  prbs_burst_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_seed  (cmd_seed),
    .cmd_len   (cmd_len),
    .cmd_abort (cmd_abort),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .err_seed  (err_seed),
    .bits_sent (bits_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference PRBS: first four bits are the seed LSB-first, then b[n+4]=b[n]^b[n+1]
  function automatic int ref_bit(input logic [3:0] seed, input int n);
    bit b[0:259];
    for (int i = 0; i < 4; i++) b[i] = seed[i];
    for (int i = 4; i <= n; i++) b[i] = b[i-4] ^ b[i-3];
    return int'(b[n]);
  endfunction

  // One command: ready_pct = handshake probability, abort_at = handshake count at
  // which abort is raised (-1 none), abort_with_hs = allow a handshake alongside it
  task automatic run_burst(input logic [3:0] seed, input int len, input int ready_pct,
                           input int abort_at, input bit abort_with_hs);
    int k;
    int cyc;
    bit rdy;
    bit abt;
    bit fin;
    bit exp_ab;
    check("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_len   = LEN_W'(len);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (seed == 4'h0) begin
      check("err_seed_pulse", int'(err_seed), 1);
      check("err_no_valid", int'(bit_valid), 0);
      check("err_busy", int'(busy), 0);
      check("err_cmd_ready", int'(cmd_ready), 1);
      check("err_bits_sent", int'(bits_sent), last_sent);
      @(negedge clk);
      check("err_seed_once", int'(err_seed), 0);
      check("err_no_done", int'(done), 0);
      return;
    end
    k = 0;
    cyc = 0;
    fin = (len == 0);
    exp_ab = 1'b0;
    while (!fin && cyc < 2000) begin
      check("bit_valid_run", int'(bit_valid), 1);
      check("bit_out", int'(bit_out), ref_bit(seed, k));
      check("run_done_low", int'(done), 0);
      abt = (abort_at >= 0) && (k >= abort_at);
      rdy = ($urandom_range(99) < 32'(ready_pct));
      if (abt && !abort_with_hs) rdy = 1'b0;
      bit_ready = rdy;
      cmd_abort = abt;
      @(posedge clk);
      @(negedge clk);
      bit_ready = 1'b0;
      cmd_abort = 1'b0;
      if (rdy) k++;
      if (rdy && k == len) fin = 1'b1;
      else if (abt) begin
        fin = 1'b1;
        exp_ab = 1'b1;
      end
      cyc++;
    end
    if (!fin) check("burst_timeout", 0, 1);
    check("done_pulse", int'(done), 1);
    check("aborted_flag", int'(aborted), int'(exp_ab));
    check("bits_sent_done", int'(bits_sent), k);
    check("done_no_valid", int'(bit_valid), 0);
    check("done_busy", int'(busy), 1);
    check("done_cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    check("done_once", int'(done), 0);
    check("aborted_once", int'(aborted), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_bits_sent_hold", int'(bits_sent), k);
    last_sent = k;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_seed = 4'h0;
    cmd_len = '0;
    cmd_abort = 1'b0;
    bit_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err_seed", int'(err_seed), 0);
    check("rst_bits_sent", int'(bits_sent), 0);
    check("rst_lfsr_bit", int'(bit_out), 1);
    reset = 1'b0;
    @(negedge clk);

    // Abort while idle is ignored
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check("idle_abort_done", int'(done), 0);
    check("idle_abort_busy", int'(busy), 0);

    run_burst(4'hF, 15, 100, -1, 1'b0);   // full period, no stalls
    run_burst(4'hF, 5, 50, -1, 1'b0);     // back-pressure
    run_burst(4'h0, 4, 100, -1, 1'b0);    // illegal seed
    run_burst(4'h8, 0, 100, -1, 1'b0);    // zero length
    run_burst(4'hF, 10, 100, 3, 1'b0);    // abort after 3 bits
    run_burst(4'hF, 10, 100, 9, 1'b1);    // abort coincident with last bit
    run_burst(4'h5, 30, 100, -1, 1'b0);   // wraps the 15-bit period

    // Reset mid-burst: drops immediately, no done
    cmd_valid = 1'b1;
    cmd_seed  = 4'h6;
    cmd_len   = LEN_W'(20);
    @(negedge clk);
    cmd_valid = 1'b0;
    bit_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bit_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_bit_valid", int'(bit_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_aborted", int'(aborted), 0);
    check("mid_rst_bits_sent", int'(bits_sent), 0);
    reset = 1'b0;
    last_sent = 0;
    @(negedge clk);
    check("post_rst_done", int'(done), 0);
    run_burst(4'hF, 4, 100, -1, 1'b0);

    // Random bursts
    for (int i = 0; i < 25; i++) begin
      int len;
      int ab;
      len = int'($urandom_range(40));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1;
      run_burst(4'($urandom_range(15)), len, 30 + int'($urandom_range(70)), ab,
                1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
